// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its issue/writeback controller:
// opcodes, status flag positions and opcode-class decode helpers.
package alu_pkg;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_LDI = 8'h01;
   localparam logic [7:0] OP_STI = 8'h02;
   localparam logic [7:0] OP_CLI = 8'h03;

   localparam logic [7:0] OP_ALU_FIRST = 8'h06;
   localparam logic [7:0] OP_ADD       = 8'h06;
   localparam logic [7:0] OP_SUB       = 8'h07;
   localparam logic [7:0] OP_INC       = 8'h0A;
   localparam logic [7:0] OP_DEC       = 8'h0B;
   localparam logic [7:0] OP_SL        = 8'h0D;
   localparam logic [7:0] OP_SR        = 8'h0E;
   localparam logic [7:0] OP_NOT       = 8'h12;
   localparam logic [7:0] OP_ROL       = 8'h16;
   localparam logic [7:0] OP_ROR       = 8'h17;
   localparam logic [7:0] OP_ALU_LAST  = 8'h17;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_S = 2;
   localparam int FLAG_P = 3;
   localparam int FLAG_I = 4;
   localparam int FLAG_D = 5;
   localparam int FLAG_O = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WRITE
   } state_t;

   function automatic logic is_alu_op(input logic [7:0] op);
      return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
   endfunction

   // Single-operand ALU ops; operand2 is forced to zero for these.
   function automatic logic is_unary(input logic [7:0] op);
      return (op == OP_INC) || (op == OP_DEC) || (op == OP_SL) || (op == OP_SR) ||
             (op == OP_NOT) || (op == OP_ROL) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/regfile8x8.sv
// 8x8 general register file: two registered read ports (port 2 can latch an
// override value instead of a register), one write port, one combinational debug port.
module regfile8x8 #(
   parameter int         NREGS     = 8,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_en,
   input  logic [2:0] rd_addr1,
   input  logic [2:0] rd_addr2,
   input  logic       rd2_ovr_en,
   input  logic [7:0] rd2_ovr_data,
   output logic [7:0] rd_data1,
   output logic [7:0] rd_data2,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [2:0] dbg_addr,
   output logic [7:0] dbg_data
);

   logic [7:0] regs [NREGS];

   // NOTE: the array is reset explicitly because every register has an
   // architectural reset value; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data1 <= 8'h00;
         rd_data2 <= 8'h00;
      end else if (rd_en) begin
         rd_data1 <= regs[rd_addr1];
         rd_data2 <= rd2_ovr_en ? rd2_ovr_data : regs[rd_addr2];
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU: accepts one instruction per
// three cycles, drives registered ALU inputs, writes back result and status.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int         NREGS     = 8,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [7:0] instr_op,
   input  logic [2:0] instr_rd,
   input  logic [2:0] instr_rs1,
   input  logic [2:0] instr_rs2,
   input  logic       instr_imm_en,
   input  logic [7:0] instr_imm,
   output logic [7:0] operand1,
   output logic [7:0] operand2,
   output logic [7:0] alu_sel,
   input  logic [7:0] alu_result,
   input  logic [6:0] alu_flags,
   output logic [6:0] status,
   output logic       wb_done,
   output logic       illegal,
   input  logic [2:0] dbg_addr,
   output logic [7:0] dbg_data
);

   state_t     state;
   logic [7:0] op_q;
   logic [2:0] rd_q;
   logic [7:0] imm_q;
   logic       accept;
   logic       rd2_ovr_en;
   logic [7:0] rd2_ovr_data;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       unused_flags;

   // Z, S, P and I are produced locally; only C, D and O come from the ALU.
   assign unused_flags = ^{alu_flags[FLAG_I], alu_flags[FLAG_P], alu_flags[FLAG_S], alu_flags[FLAG_Z]};

   assign instr_ready = (state == S_IDLE);
   assign accept      = instr_ready && instr_valid;

   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      rd2_ovr_en   = 1'b0;
      rd2_ovr_data = instr_imm;
      if (is_unary(instr_op)) begin
         rd2_ovr_en   = 1'b1;
         rd2_ovr_data = 8'h00;
      end else if (instr_imm_en) begin
         rd2_ovr_en   = 1'b1;
      end
   end

   assign wr_en   = (state == S_WRITE) && (is_alu_op(op_q) || (op_q == OP_LDI));
   assign wr_data = is_alu_op(op_q) ? alu_result : imm_q;

   regfile8x8 #(
      .NREGS     (NREGS),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_en        (accept),
      .rd_addr1     (instr_rs1),
      .rd_addr2     (instr_rs2),
      .rd2_ovr_en   (rd2_ovr_en),
      .rd2_ovr_data (rd2_ovr_data),
      .rd_data1     (operand1),
      .rd_data2     (operand2),
      .wr_en        (wr_en),
      .wr_addr      (rd_q),
      .wr_data      (wr_data),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         op_q    <= OP_NOP;
         rd_q    <= 3'd0;
         imm_q   <= 8'h00;
         alu_sel <= OP_NOP;
         status  <= 7'h00;
         wb_done <= 1'b0;
         illegal <= 1'b0;
      end else begin
         wb_done <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  op_q    <= instr_op;
                  rd_q    <= instr_rd;
                  imm_q   <= instr_imm;
                  alu_sel <= is_alu_op(instr_op) ? instr_op : OP_NOP;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WRITE;
            S_WRITE: begin
               state <= S_IDLE;
               if (is_alu_op(op_q)) begin
                  status[FLAG_Z] <= (alu_result == 8'h00);
                  status[FLAG_C] <= alu_flags[FLAG_C];
                  status[FLAG_S] <= alu_result[7];
                  status[FLAG_P] <= ~^alu_result;
                  status[FLAG_D] <= alu_flags[FLAG_D];
                  status[FLAG_O] <= alu_flags[FLAG_O];
                  wb_done        <= 1'b1;
               end else begin
                  case (op_q)
                     OP_NOP, OP_LDI: wb_done <= 1'b1;
                     OP_STI: begin
                        status[FLAG_I] <= 1'b1;
                        wb_done        <= 1'b1;
                     end
                     OP_CLI: begin
                        status[FLAG_I] <= 1'b0;
                        wb_done        <= 1'b1;
                     end
                     default: illegal <= 1'b1;
                  endcase
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU model
// (registered, one cycle) standing in for the real ALU.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [7:0] instr_op = 8'h00;
   logic [2:0] instr_rd = 3'd0;
   logic [2:0] instr_rs1 = 3'd0;
   logic [2:0] instr_rs2 = 3'd0;
   logic       instr_imm_en = 1'b0;
   logic [7:0] instr_imm = 8'h00;
   logic [7:0] operand1, operand2, alu_sel;
   logic [7:0] alu_result = 8'h00;
   logic [6:0] alu_flags = 7'h00;
   logic [6:0] status;
   logic       wb_done, illegal;
   logic [2:0] dbg_addr = 3'd0;
   logic [7:0] dbg_data;

   int n_cmp = 0;
   int n_fail = 0;

   always #10 clk = ~clk;

   alu_issue_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_op     (instr_op),
      .instr_rd     (instr_rd),
      .instr_rs1    (instr_rs1),
      .instr_rs2    (instr_rs2),
      .instr_imm_en (instr_imm_en),
      .instr_imm    (instr_imm),
      .operand1     (operand1),
      .operand2     (operand2),
      .alu_sel      (alu_sel),
      .alu_result   (alu_result),
      .alu_flags    (alu_flags),
      .status       (status),
      .wb_done      (wb_done),
      .illegal      (illegal),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   // Behavioural ALU: registers its inputs each edge. Flag bits the controller
   // must recompute itself (Z, S, P, I positions) are driven to 1 as decoys.
   always @(posedge clk) begin
      logic [8:0] sum;
      logic [7:0] res;
      logic       c, o;
      sum = 9'd0;
      c = 1'b0;
      o = 1'b0;
      case (alu_sel)
         8'h06: begin
            sum = {1'b0, operand1} + {1'b0, operand2};
            res = sum[7:0];
            c = sum[8];
            o = (operand1[7] == operand2[7]) && (res[7] != operand1[7]);
         end
         8'h07: begin
            res = operand1 - operand2;
            c = (operand1 < operand2);
            o = (operand1[7] != operand2[7]) && (res[7] != operand1[7]);
         end
         8'h0A: begin
            res = operand1 + 8'd1;
            c = (operand1 == 8'hFF);
            o = (operand1 == 8'h7F);
         end
         8'h0B: begin
            res = operand1 - 8'd1;
            c = (operand1 == 8'h00);
            o = (operand1 == 8'h80);
         end
         default: res = operand1 ^ operand2;
      endcase
      alu_result <= res;
      alu_flags  <= {o, 1'b0, 1'b1, 1'b1, 1'b1, c, 1'b1};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] op;
      logic [2:0] rd, rs1, rs2;
      logic       imm_en;
      logic [7:0] imm;
      logic [7:0] e_op1, e_op2, e_sel;
      logic       e_wb, e_ill;
      logic [7:0] e_rdv;
      logic [6:0] e_status;
   } vec_t;

   vec_t vecs[15];

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called just after a posedge; accept happens at the next edge (k).
   task automatic run_vec(input vec_t v, input int idx);
      instr_op = v.op;  instr_rd = v.rd;  instr_rs1 = v.rs1;  instr_rs2 = v.rs2;
      instr_imm_en = v.imm_en;  instr_imm = v.imm;  instr_valid = 1'b1;
      dbg_addr = v.rd;
      @(negedge clk);
      check($sformatf("v%0d ready_idle", idx), instr_ready, 1'b1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      check($sformatf("v%0d operand1", idx), operand1, v.e_op1);
      check($sformatf("v%0d operand2", idx), operand2, v.e_op2);
      check($sformatf("v%0d alu_sel", idx), alu_sel, v.e_sel);
      check($sformatf("v%0d ready_issue", idx), instr_ready, 1'b0);
      check($sformatf("v%0d early_wb", idx), wb_done, 1'b0);
      @(posedge clk); #1;
      check($sformatf("v%0d ready_write", idx), instr_ready, 1'b0);
      @(posedge clk); #1;
      check($sformatf("v%0d wb_done", idx), wb_done, v.e_wb);
      check($sformatf("v%0d illegal", idx), illegal, v.e_ill);
      check($sformatf("v%0d R[rd]", idx), dbg_data, v.e_rdv);
      check($sformatf("v%0d status", idx), status, v.e_status);
      @(posedge clk); #1;
      check($sformatf("v%0d wb_clear", idx), wb_done, 1'b0);
   endtask

   initial begin
      //           op     rd    rs1   rs2   ie    imm     op1    op2    sel    wb ill rdv    status
      vecs[0]  = '{8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h00, 1, 0, 8'h05, 7'h00}; // LDI R1,05
      vecs[1]  = '{8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 8'h03, 8'h00, 8'h03, 8'h00, 1, 0, 8'h03, 7'h00}; // LDI R2,03
      vecs[2]  = '{8'h06, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h05, 8'h03, 8'h06, 1, 0, 8'h08, 7'h00}; // ADD R3
      vecs[3]  = '{8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'h80, 8'h00, 8'h80, 8'h00, 1, 0, 8'h80, 7'h00}; // LDI R1,80
      vecs[4]  = '{8'h07, 3'd4, 3'd1, 3'd0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h07, 1, 0, 8'h00, 7'h09}; // SUB R4 imm
      vecs[5]  = '{8'h01, 3'd5, 3'd0, 3'd0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1, 0, 8'hFF, 7'h09}; // LDI R5,FF
      vecs[6]  = '{8'h0A, 3'd5, 3'd5, 3'd1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h0A, 1, 0, 8'h00, 7'h0B}; // INC R5
      vecs[7]  = '{8'h20, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h80, 8'h03, 8'h00, 0, 1, 8'h08, 7'h0B}; // illegal
      vecs[8]  = '{8'h02, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 7'h1B}; // STI
      vecs[9]  = '{8'h06, 3'd6, 3'd2, 3'd3, 1'b0, 8'h00, 8'h03, 8'h08, 8'h06, 1, 0, 8'h0B, 7'h10}; // ADD keeps I
      vecs[10] = '{8'h06, 3'd7, 3'd1, 3'd0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h06, 1, 0, 8'h00, 7'h5B}; // ADD carry+ovf
      vecs[11] = '{8'h03, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 7'h4B}; // CLI
      vecs[12] = '{8'h00, 3'd6, 3'd3, 3'd6, 1'b0, 8'h00, 8'h08, 8'h0B, 8'h00, 1, 0, 8'h0B, 7'h4B}; // NOP
      vecs[13] = '{8'h06, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00, 8'h03, 8'h03, 8'h06, 1, 0, 8'h06, 7'h08}; // ADD rd==rs
      vecs[14] = '{8'h0B, 3'd7, 3'd6, 3'd1, 1'b1, 8'h55, 8'h0B, 8'h00, 8'h0B, 1, 0, 8'h0A, 7'h08}; // DEC, imm ignored

      do_reset();
      #1;
      check("rst operand1", operand1, 8'h00);
      check("rst operand2", operand2, 8'h00);
      check("rst alu_sel", alu_sel, 8'h00);
      check("rst status", status, 7'h00);
      check("rst wb_done", wb_done, 1'b0);
      check("rst illegal", illegal, 1'b0);
      check("rst ready", instr_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check($sformatf("rst R%0d", i), dbg_data, 8'h00);
      end

      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // Back-to-back: valid held high for three LDIs; accepts every third edge.
      begin
         logic [9:0] exp_ready;
         int         n_acc;
         int         n_wb;
         logic [7:0] ldi_val [3];
         ldi_val[0] = 8'h11;  ldi_val[1] = 8'h22;  ldi_val[2] = 8'h33;
         exp_ready = 10'b10_0100_1001;
         n_acc = 0;
         n_wb = 0;
         instr_op = 8'h01;  instr_imm_en = 1'b1;  instr_rs1 = 3'd0;  instr_rs2 = 3'd0;
         instr_rd = 3'd1;   instr_imm = ldi_val[0];  instr_valid = 1'b1;
         for (int c = 0; c < 10; c++) begin
            logic rdy;
            @(negedge clk);
            rdy = instr_ready;
            check($sformatf("b2b ready c%0d", c), rdy, exp_ready[c]);
            if (wb_done) n_wb++;
            @(posedge clk); #1;
            if (rdy && instr_valid) begin
               n_acc++;
               if (n_acc < 3) begin
                  instr_rd  = 3'(n_acc + 1);
                  instr_imm = ldi_val[n_acc];
               end else begin
                  instr_valid = 1'b0;
               end
            end
         end
         check("b2b accepts", n_acc, 3);
         check("b2b wb pulses", n_wb, 3);
         for (int r = 0; r < 3; r++) begin
            dbg_addr = 3'(r + 1);
            #1;
            check($sformatf("b2b R%0d", r + 1), dbg_data, ldi_val[r]);
         end
      end

      // Reset during ISSUE of ADD R6 aborts it.
      begin
         vec_t ldi;
         logic seen_wb;
         do_reset();
         @(posedge clk); #1;
         ldi = '{8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 8'h12, 8'h00, 8'h12, 8'h00, 1, 0, 8'h12, 7'h00};
         run_vec(ldi, 99);
         instr_op = 8'h06;  instr_rd = 3'd6;  instr_rs1 = 3'd1;  instr_rs2 = 3'd1;
         instr_imm_en = 1'b0;  instr_valid = 1'b1;
         @(posedge clk); #1;
         instr_valid = 1'b0;
         check("abort accepted op1", operand1, 8'h12);
         check("abort accepted sel", alu_sel, 8'h06);
         #2 rst_n = 1'b0;
         #1;
         check("abort operand1", operand1, 8'h00);
         check("abort operand2", operand2, 8'h00);
         check("abort alu_sel", alu_sel, 8'h00);
         check("abort ready", instr_ready, 1'b1);
         seen_wb = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_done) seen_wb = 1'b1;
         end
         check("abort no wb_done", seen_wb, 1'b0);
         check("abort ready idle", instr_ready, 1'b1);
         check("abort status", status, 7'h00);
         dbg_addr = 3'd6;
         #1;
         check("abort R6", dbg_data, 8'h00);
         dbg_addr = 3'd1;
         #1;
         check("abort R1 reset", dbg_data, 8'h00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
